// File: rtl/cheat_pgm_loader_if.sv
// MCU frame port and cheat-engine programming bus of cheat_pgm_loader.
// master: MCU/bench side; slave: the loader.
interface cheat_pgm_loader_if;
  logic        mcu_frame_start;
  logic        mcu_data_strobe;
  logic [7:0]  mcu_data;
  logic        pgm_stall;
  logic [2:0]  pgm_idx;
  logic        pgm_we;
  logic [31:0] pgm_in;

  modport master (
    output mcu_frame_start,
    output mcu_data_strobe,
    output mcu_data,
    output pgm_stall,
    input  pgm_idx,
    input  pgm_we,
    input  pgm_in
  );

  modport slave (
    input  mcu_frame_start,
    input  mcu_data_strobe,
    input  mcu_data,
    input  pgm_stall,
    output pgm_idx,
    output pgm_we,
    output pgm_in
  );
endinterface

// File: rtl/cheat_pgm_loader.sv
// Buffers a checksummed MCU frame of up to 8 words, then commits it to the
// cheat engine. Ports: clk, rst, bus (slave), busy, done, err, overrun.
module cheat_pgm_loader #(
  parameter bit CHECK_CSUM = 1'b1
) (
  input  logic clk,
  input  logic rst,
  cheat_pgm_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic err,
  output logic overrun
);

  typedef enum logic [2:0] {
    IDLE, HDR, PAYLOAD, CSUM, SAFE, COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  base_q;
  logic [2:0]  nm1_q;
  logic [2:0]  wcnt_q;
  logic        safe_q;
  logic [4:0]  bcnt_q;
  logic [7:0]  sum_q;
  logic [31:0] buf_q [8];

  logic       start, stb;
  logic [7:0] din;
  logic [7:0] sum_c;
  logic hdr_ld, pay_ld, wadv;
  logic done_d, err_d, ovr_set, start_ok;

  assign start = bus.mcu_frame_start;
  assign stb   = bus.mcu_data_strobe;
  assign din   = bus.mcu_data;
  assign sum_c = sum_q + din;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    hdr_ld   = 1'b0;
    pay_ld   = 1'b0;
    wadv     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ovr_set  = 1'b0;
    start_ok = 1'b0;
    unique case (state_q)
      SAFE: begin
        ovr_set = start | stb;
        if (!bus.pgm_stall) state_d = COMMIT;
      end
      COMMIT: begin
        ovr_set = start | stb;
        if (!bus.pgm_stall) begin
          wadv = 1'b1;
          if (wcnt_q == nm1_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        // A start always wins; a byte in the same cycle is the header.
        if (start) begin
          start_ok = 1'b1;
          state_d  = HDR;
          hdr_ld   = stb;
        end else if (stb) begin
          unique case (state_q)
            HDR: hdr_ld = 1'b1;
            PAYLOAD: begin
              pay_ld = 1'b1;
              if (bcnt_q == {nm1_q, 2'b11}) state_d = CSUM;
            end
            CSUM: begin
              if (CHECK_CSUM && sum_c != 8'h00) begin
                err_d   = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = safe_q ? SAFE : COMMIT;
              end
            end
            default: ;
          endcase
        end
        if (hdr_ld) begin
          if (din[3]) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
    endcase
  end

  // Stall gates the strobe in the same cycle; counters hold meanwhile.
  assign bus.pgm_we = (state_q == SAFE || state_q == COMMIT) &&
                      !bus.pgm_stall;

  always_comb begin
    bus.pgm_idx = 3'd0;
    bus.pgm_in  = 32'h0;
    if (state_q == SAFE) begin
      bus.pgm_idx = 3'd6;
    end else if (state_q == COMMIT) begin
      bus.pgm_idx = base_q + wcnt_q;
      bus.pgm_in  = buf_q[wcnt_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= 3'd0;
      nm1_q   <= 3'd0;
      wcnt_q  <= 3'd0;
      safe_q  <= 1'b0;
      bcnt_q  <= 5'd0;
      sum_q   <= 8'h00;
      done    <= 1'b0;
      err     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= done_d;
      err  <= err_d;
      if (start_ok)     overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      if (hdr_ld) begin
        base_q <= din[7:5];
        safe_q <= din[4];
        nm1_q  <= din[2:0];
        sum_q  <= din;
        bcnt_q <= 5'd0;
        wcnt_q <= 3'd0;
      end
      if (pay_ld) begin
        sum_q  <= sum_c;
        bcnt_q <= bcnt_q + 5'd1;
      end
      if (wadv) wcnt_q <= wcnt_q + 3'd1;
    end
  end

  // Big-endian packing: first byte of a word lands in [31:24].
  always_ff @(posedge clk) begin
    if (pay_ld) begin
      unique case (bcnt_q[1:0])
        2'd0: buf_q[bcnt_q[4:2]][31:24] <= din;
        2'd1: buf_q[bcnt_q[4:2]][23:16] <= din;
        2'd2: buf_q[bcnt_q[4:2]][15:8]  <= din;
        2'd3: buf_q[bcnt_q[4:2]][7:0]   <= din;
      endcase
    end
  end

endmodule
